// File: rtl/csa_accum_pkg.sv
// ============================================================================
// Module      : csa_accum_pkg
// Description : Shared types, default sizing and the operand-count clamp used
//               by the carry-save accumulator controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package csa_accum_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_MAX_OPS = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Requests larger than the accumulator was sized for are truncated to
    // MAX_OPS so the result width can never overflow.
    function automatic int unsigned clamp_ops(input int unsigned n,
                                              input int unsigned max_ops);
        return (n > max_ops) ? max_ops : n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/csa_row.sv
// ============================================================================
// Module      : csa_row
// Description : Combinational 3:2 compressor row; carry output is unshifted.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csa_row #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] s,
    output logic [W-1:0] co
);

    assign s  = a ^ b ^ c;
    assign co = (a & b) | (a & c) | (b & c);

endmodule

`default_nettype wire

// File: rtl/csa_accum_ctrl.sv
// ============================================================================
// Module      : csa_accum_ctrl
// Description : Multi-operand summer: carry-save accumulation of up to MAX_OPS
//               operands followed by a single carry-propagate add.
//               Optional abort port enabled by defining CSA_ABORT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csa_accum_ctrl
    import csa_accum_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_OPS   = DEF_MAX_OPS,
    parameter int OUT_WIDTH = WIDTH + $clog2(MAX_OPS),
    parameter int CNT_W     = $clog2(MAX_OPS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_ops,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] out_data,
`ifdef CSA_ABORT_EN
    input  logic                 abort,
`endif
    input  logic                 out_ready,
    output logic                 busy
);

    state_t               state_q,    state_d;
    logic [CNT_W-1:0]     target_q,   target_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic [OUT_WIDTH-1:0] sum_q,      sum_d;
    logic [OUT_WIDTH-1:0] carry_q,    carry_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;

    logic                 abort_req;
    logic                 accept;
    logic                 last_op;
    logic [CNT_W-1:0]     req_target;
    logic [OUT_WIDTH-1:0] op_ext;
    logic [OUT_WIDTH-1:0] row_s;
    logic [OUT_WIDTH-1:0] row_co;

`ifdef CSA_ABORT_EN
    // Abort only cancels a job that has not yet produced its result.
    assign abort_req = abort && ((state_q == ACCUM) || (state_q == RESOLVE));
`else
    assign abort_req = 1'b0;
`endif

    assign req_target = CNT_W'(clamp_ops(32'(num_ops), MAX_OPS));
    assign accept     = (state_q == ACCUM) && in_valid;
    assign last_op    = (cnt_q + 1'b1) == target_q;
    assign op_ext     = OUT_WIDTH'(in_data);

    csa_row #(
        .W (OUT_WIDTH)
    ) u_row (
        .a  (sum_q),
        .b  (carry_q),
        .c  (op_ext),
        .s  (row_s),
        .co (row_co)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (req_target == '0) ? RESOLVE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept && last_op) begin
                    state_d = RESOLVE;
                end
            end
            RESOLVE: state_d = DONE;
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort_req) begin
            state_d = IDLE;
        end
    end

    // Output logic
    always_comb begin
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
    end

    // Datapath next values
    always_comb begin
        target_d   = target_q;
        cnt_d      = cnt_q;
        sum_d      = sum_q;
        carry_d    = carry_q;
        out_data_d = out_data_q;
        if ((state_q == IDLE) && start) begin
            target_d = req_target;
            cnt_d    = '0;
            sum_d    = '0;
            carry_d  = '0;
        end
        if (accept) begin
            // Carry weight moves up one bit; the MSB drop cannot lose value
            // because OUT_WIDTH bounds the total.
            sum_d   = row_s;
            carry_d = row_co << 1;
            cnt_d   = cnt_q + 1'b1;
        end
        if ((state_q == RESOLVE) && !abort_req) begin
            out_data_d = sum_q + carry_q;
        end
        if (abort_req) begin
            cnt_d   = '0;
            sum_d   = '0;
            carry_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            target_q   <= '0;
            cnt_q      <= '0;
            sum_q      <= '0;
            carry_q    <= '0;
            out_data_q <= '0;
        end else begin
            target_q   <= target_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            carry_q    <= carry_d;
            out_data_q <= out_data_d;
        end
    end

    assign out_data = out_data_q;

endmodule

`default_nettype wire

// File: tb/tb_csa_accum_ctrl.sv
// ============================================================================
// Module      : tb_csa_accum_ctrl
// Description : Scoreboard bench for csa_accum_ctrl; abort job runs only when
//               CSA_ABORT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csa_accum_ctrl;

    localparam int WIDTH     = 8;
    localparam int MAX_OPS   = 8;
    localparam int OUT_WIDTH = WIDTH + $clog2(MAX_OPS);
    localparam int CNT_W     = $clog2(MAX_OPS + 1);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [CNT_W-1:0]     num_ops = '0;
    logic                 in_valid = 1'b0;
    logic [WIDTH-1:0]     in_data = '0;
    logic                 in_ready;
    logic                 out_valid;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_ready = 1'b1;
    logic                 busy;
    logic                 abort_in = 1'b0;

    typedef struct {
        int unsigned data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned ops_q[$];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic        prev_valid = 1'b0;

    csa_accum_ctrl #(
        .WIDTH   (WIDTH),
        .MAX_OPS (MAX_OPS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_ops   (num_ops),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
`ifdef CSA_ABORT_EN
        .abort     (abort_in),
`endif
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every presented result against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                if (!prev_valid) check("out_latency_cycle", cyc, sb[0].cyc);
                check("out_data", out_data, sb[0].data);
                if (out_ready) void'(sb.pop_front());
            end
        end
        prev_valid = out_valid;
    end

    // n: num_ops; operands from ops_q; push expected on the last operand.
    task automatic run_job(input int n, input int unsigned exp, input bit gap, input bit push);
        int k;
        int start_cyc;
        @(posedge clk); #1;
        start   = 1'b1;
        num_ops = CNT_W'(n);
        @(negedge clk);
        start_cyc = cyc;
        if (push && ops_q.size() == 0) sb.push_back('{exp, start_cyc + 2});
        @(posedge clk); #1;
        start = 1'b0;
        if (ops_q.size() == 0) begin
            repeat (2) begin
                @(negedge clk);
                check("zero_len_in_ready", in_ready, 0);
            end
        end
        for (int i = 0; i < ops_q.size(); i++) begin
            if (gap && i > 0) begin
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = WIDTH'(ops_q[i]);
            @(negedge clk);
            k = 0;
            while (!in_ready && k < 20) begin
                @(negedge clk);
                k++;
            end
            if (!in_ready) begin
                check("in_ready_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            if (push && i == ops_q.size() - 1) sb.push_back('{exp, cyc + 2});
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while (busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("wait_idle_busy", busy, 0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic: 3+5+7
        ops_q = {3, 5, 7};
        run_job(3, 15, 1'b0, 1'b1);
        wait_idle();

        // Full scale: 8 x 255 = 2040
        ops_q = {};
        for (int i = 0; i < 8; i++) ops_q.push_back(255);
        run_job(8, 2040, 1'b0, 1'b1);
        wait_idle();

        // Zero length
        ops_q = {};
        run_job(0, 0, 1'b0, 1'b1);
        wait_idle();

        // Gaps and backpressure, start pulsed in DONE
        out_ready = 1'b0;
        ops_q = {1, 2, 4, 8};
        run_job(4, 15, 1'b1, 1'b1);
        begin
            int k = 0;
            @(negedge clk);
            while (!out_valid && k < 20) begin
                @(negedge clk);
                k++;
            end
            check("bp_out_valid_seen", out_valid, 1);
        end
        @(posedge clk); #1;
        start   = 1'b1;
        num_ops = CNT_W'(2);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_out_valid_held", out_valid, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("after_done_busy", busy, 0);
        check("after_done_out_valid", out_valid, 0);

        // Mid-job reset after 2 of 4 operands
        ops_q = {6, 9};
        run_job(4, 0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_out_data", out_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Clamp: num_ops=12 takes only 8 operands
        ops_q = {};
        for (int i = 0; i < 8; i++) ops_q.push_back(1);
        run_job(12, 8, 1'b0, 1'b1);
        @(negedge clk);
        check("clamp_in_ready_after_8", in_ready, 0);
        wait_idle();

`ifdef CSA_ABORT_EN
        // Abort after 2 of 5 operands
        ops_q = {9, 9};
        run_job(5, 0, 1'b0, 1'b0);
        abort_in = 1'b1;
        @(posedge clk); #1;
        abort_in = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        repeat (4) @(negedge clk);
        ops_q = {10, 20};
        run_job(2, 30, 1'b0, 1'b1);
        wait_idle();
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
